// File: rtl/pwm_fade_ctrl.sv
// Breathing/fade sequencer: free-running PWM period counter plus a duty ramp FSM.
// Define PWM_FADE_CTRL_GAMMA_EN to compare against duty^2 >> DUTY_W instead of linear duty.
module pwm_fade_ctrl #(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] step,
  input  logic [7:0]        rate,
  input  logic [HOLD_W-1:0] hold_hi,
  input  logic [HOLD_W-1:0] hold_lo,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty,
  output logic [2:0]        state,
  output logic              period_end,
  output logic              cycle_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HI   = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LO   = 3'd4
  } state_t;

  localparam logic [DUTY_W-1:0] MAX = {DUTY_W{1'b1}};

  state_t            st;
  logic [DUTY_W-1:0] cnt;
  logic [7:0]        div;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DUTY_W-1:0] step_eff;
  logic [7:0]        rate_eff;
  logic [DUTY_W-1:0] duty_cmp;
  logic              wrap;
  logic              tick;

  assign step_eff   = (step == '0) ? DUTY_W'(1) : step;
  assign rate_eff   = (rate == 8'd0) ? 8'd1 : rate;
  assign wrap       = !rst && en && (cnt == MAX);
  assign tick       = wrap && (div == rate_eff - 8'd1);
  assign period_end = wrap;
  assign cycle_done = tick && (st == HOLD_LO) && (hold_cnt >= hold_lo);
  assign pwm        = !rst && en && (cnt < duty_cmp);
  assign state      = st;

`ifdef PWM_FADE_CTRL_GAMMA_EN
  // Squared duty gives a roughly perceptual (gamma ~2) brightness curve.
  logic [2*DUTY_W-1:0] duty_sq;
  assign duty_sq  = {{DUTY_W{1'b0}}, duty} * {{DUTY_W{1'b0}}, duty};
  assign duty_cmp = duty_sq[2*DUTY_W-1:DUTY_W];
`else
  assign duty_cmp = duty;
`endif

  // Counter, tick divider and fade FSM; duty only moves on a wrap clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div      <= 8'd0;
      hold_cnt <= '0;
      duty     <= '0;
      st       <= IDLE;
    end else if (!en) begin
      cnt      <= '0;
      div      <= 8'd0;
      hold_cnt <= '0;
      duty     <= '0;
      st       <= IDLE;
    end else begin
      cnt <= cnt + DUTY_W'(1);
      if (tick)
        div <= 8'd0;
      else if (wrap)
        div <= div + 8'd1;

      case (st)
        IDLE: begin
          st   <= RAMP_UP;
          duty <= '0;
        end
        RAMP_UP: if (tick) begin
          if (MAX - duty <= step_eff) begin
            duty     <= MAX;
            st       <= HOLD_HI;
            hold_cnt <= '0;
          end else begin
            duty <= duty + step_eff;
          end
        end
        HOLD_HI: if (tick) begin
          if (hold_cnt >= hold_hi) begin
            st       <= RAMP_DOWN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RAMP_DOWN: if (tick) begin
          if (duty <= step_eff) begin
            duty     <= '0;
            st       <= HOLD_LO;
            hold_cnt <= '0;
          end else begin
            duty <= duty - step_eff;
          end
        end
        HOLD_LO: if (tick) begin
          if (hold_cnt >= hold_lo) begin
            st       <= RAMP_UP;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: cycle-level reference model, directed
// literal checks of the fade sequence, then randomized configuration runs.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] step = 8'd64;
  logic [7:0] rate = 8'd1;
  logic [7:0] hold_hi = 8'd0;
  logic [7:0] hold_lo = 8'd0;
  logic       pwm;
  logic [7:0] duty;
  logic [2:0] state;
  logic       period_end;
  logic       cycle_done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt = 0, m_div = 0, m_hold = 0, m_duty = 0, m_state = 0;
  // per-period pwm high count and cycle_done pulse count
  int acc = 0, last_hi = 0, cd_cnt = 0;

  pwm_fade_ctrl #(.DUTY_W(8), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .step(step), .rate(rate),
    .hold_hi(hold_hi), .hold_lo(hold_lo), .pwm(pwm), .duty(duty),
    .state(state), .period_end(period_end), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  function automatic int cmp_of(input int d);
`ifdef PWM_FADE_CTRL_GAMMA_EN
    return (d * d) / 256;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one fade step per tick, ticks every rate periods of 256 clocks.
  always @(posedge clk or posedge rst) begin
    int se, re;
    bit w, t;
    if (rst) begin
      m_cnt = 0; m_div = 0; m_hold = 0; m_duty = 0; m_state = 0;
    end else if (!en) begin
      m_cnt = 0; m_div = 0; m_hold = 0; m_duty = 0; m_state = 0;
    end else begin
      se = (step == 0) ? 1 : int'(step);
      re = (rate == 0) ? 1 : int'(rate);
      w = (m_cnt == 255);
      t = w && (m_div == re - 1);
      m_cnt = (m_cnt + 1) % 256;
      if (t) m_div = 0;
      else if (w) m_div = (m_div + 1) % 256;
      if (m_state == 0) begin
        m_state = 1; m_duty = 0;
      end else if (t) begin
        if (m_state == 1) begin
          if (m_duty + se >= 255) begin m_duty = 255; m_state = 2; m_hold = 0; end
          else m_duty = m_duty + se;
        end else if (m_state == 2) begin
          if (m_hold >= int'(hold_hi)) begin m_state = 3; m_hold = 0; end
          else m_hold++;
        end else if (m_state == 3) begin
          if (m_duty - se <= 0) begin m_duty = 0; m_state = 4; m_hold = 0; end
          else m_duty = m_duty - se;
        end else begin
          if (m_hold >= int'(hold_lo)) begin m_state = 1; m_hold = 0; end
          else m_hold++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int re;
    bit t_now;
    re = (rate == 0) ? 1 : int'(rate);
    t_now = !rst && en && (m_cnt == 255) && (m_div == re - 1);
    check("pwm", int'(pwm), int'(!rst && en && (m_cnt < cmp_of(m_duty))));
    check("duty", int'(duty), m_duty);
    check("state", int'(state), m_state);
    check("period_end", int'(period_end), int'(!rst && en && m_cnt == 255));
    check("cycle_done", int'(cycle_done), int'(t_now && m_state == 4 && m_hold >= int'(hold_lo)));
    if (period_end) begin
      last_hi = acc + int'(pwm);
      acc = 0;
    end else if (!en || rst) begin
      acc = 0;
    end else begin
      acc += int'(pwm);
    end
    cd_cnt += int'(cycle_done);
  end

  // Wait for a period_end, then return on the first clock of the next period.
  task automatic run_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (period_end) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_duty[17];
    int exp_st[17];
    int hi64, hi255, len;
    bit ok;
    exp_duty = '{64, 128, 192, 255, 255, 191, 127, 63, 0, 0, 64, 128, 192, 255, 255, 191, 127};
    exp_st   = '{1, 1, 1, 2, 3, 3, 3, 3, 4, 1, 1, 1, 1, 2, 3, 3, 3};
`ifdef PWM_FADE_CTRL_GAMMA_EN
    hi64 = 16; hi255 = 254;
`else
    hi64 = 64; hi255 = 255;
`endif

    // Reset held with en=1
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_state", int'(state), 0);
    check("rst_period_end", int'(period_end), 0);
    check("rst_cycle_done", int'(cycle_done), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("start_state", int'(state), 1);
    cd_cnt = 0;

    // Full fade cycle with step 64, then into a second ramp
    for (int k = 0; k < 17; k++) begin
      run_period(ok);
      check("ramp_timeout", int'(ok), 1);
      check("ramp_duty", int'(duty), exp_duty[k]);
      check("ramp_state", int'(state), exp_st[k]);
      if (k == 1) check("pwm_hi_64", last_hi, hi64);
      if (k == 4) check("pwm_hi_255", last_hi, hi255);
      if (k == 9) check("cycle_done_count", cd_cnt, 1);
    end

    // Abort during RAMP_DOWN at duty 127
    #1 en = 1'b0;
    #1 check("abort_pwm", int'(pwm), 0);
    check("abort_period_end", int'(period_end), 0);
    @(negedge clk);
    check("abort_state", int'(state), 0);
    check("abort_duty", int'(duty), 0);
    #1 en = 1'b1;
    @(negedge clk);
    check("reenable_state", int'(state), 1);
    check("reenable_duty", int'(duty), 0);

    // Zero step/rate behave as 1
    #1 en = 1'b0; step = 8'd0; rate = 8'd0;
    @(negedge clk);
    #1 en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      run_period(ok);
      check("zero_cfg_timeout", int'(ok), 1);
      check("zero_cfg_duty", int'(duty), k);
    end

    // Rate 3, hold_hi 2: update every 3 periods, HOLD_HI spans 9 periods
    #1 en = 1'b0; step = 8'd128; rate = 8'd3; hold_hi = 8'd2; hold_lo = 8'd0;
    @(negedge clk);
    #1 en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      run_period(ok);
      check("rate_timeout", int'(ok), 1);
      if (k == 2) check("rate_no_tick", int'(duty), 0);
      if (k == 3) check("rate_first_tick", int'(duty), 128);
      if (k == 6) check("rate_hold_entry", int'(state), 2);
      if (k == 14) check("rate_hold_still", int'(state), 2);
      if (k == 15) check("rate_hold_exit", int'(state), 3);
    end

    // Async reset mid-HOLD_HI
    #1 en = 1'b0; step = 8'd255; rate = 8'd1; hold_hi = 8'd5;
    @(negedge clk);
    #1 en = 1'b1;
    run_period(ok);
    check("hold_entry_state", int'(state), 2);
    check("hold_entry_duty", int'(duty), 255);
    repeat (100) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst_duty", int'(duty), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_pwm", int'(pwm), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Randomized configurations with occasional live changes, dropouts and resets
    for (int seg = 0; seg < 20; seg++) begin
      @(negedge clk);
      #1 en = 1'b0;
      step = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8));
      rate = 8'($urandom_range(0, 3));
      hold_hi = 8'($urandom_range(0, 3));
      hold_lo = 8'($urandom_range(0, 3));
      @(negedge clk);
      #1 en = 1'b1;
      len = int'($urandom_range(300, 2500));
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        #1;
        rst = ($urandom_range(0, 999) == 0);
        en = ($urandom_range(0, 999) != 0);
        if ($urandom_range(0, 199) == 0) step = 8'($urandom);
        if ($urandom_range(0, 499) == 0) hold_hi = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 499) == 0) hold_lo = 8'($urandom_range(0, 3));
      end
      #1 rst = 1'b0;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
